// File: rtl/memory_access_cycle.sv
// Memory (M) stage of a 5-stage RISC-V pipeline.
// Issues one load or store at a time on a req/gnt/rvalid data port. It stalls
// the upstream pipeline until the access finishes or times out. It also owns the
// M->W pipeline register.
//
// Ports
//   clk, rst (async, active-low)
//   M bundle in : RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
//   Memory port : mem_req/mem_we/mem_addr/mem_wdata out, mem_gnt/mem_rvalid/mem_rdata in
//   Control out : StallM (freeze PC..EX/M), mem_err (one-cycle pulse on timeout abort)
//   W bundle out: RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
module memory_access_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        mem_err,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;

  logic memop, is_store, is_load, timeout;

  assign memop    = MemWriteM | ResultSrcM;
  // Store wins when both flags are set.
  assign is_store = MemWriteM;
  assign is_load  = ResultSrcM & ~MemWriteM;
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES));

  assign mem_we    = MemWriteM;
  assign mem_addr  = ALU_ResultM;
  assign mem_wdata = WriteDataM;
  assign mem_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    abort_d = abort_q;
    mem_req = 1'b0;
    StallM  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          StallM  = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        StallM = 1'b1;
        if (timeout) begin
          // Request is withdrawn in the abort cycle so a late gnt cannot be taken.
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          mem_req = 1'b1;
          if (mem_gnt) begin
            state_d = is_store ? StDone : StWait;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWait: begin
        StallM = 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          abort_d = 1'b1;
          state_d = StDone;
        end else if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // M->W register: bubble while stalled, otherwise advance the bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      // abort_q is stale outside DONE, so only trust it there.
      RegWriteW   <= RegWriteM & ~((state_q == StDone) & abort_q);
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= is_load ? rdata_q : 32'h0;
    end
  end

endmodule
